// File: rtl/easy_timer_pkg.sv
// Shared register map, control-bit layout and FSM state encoding for the
// Avalon-MM master that drives the 16-bit interval-timer slave.
package easy_timer_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        STOP_WR,
        CLR_ST,
        SNAP_WR,
        RD_L,
        RD_H,
        RD_DONE
    } state_t;

    function automatic logic [15:0] control_word(input logic ito, input logic cont,
                                                 input logic start, input logic stop);
        logic [15:0] word;
        word             = '0;
        word[CTRL_ITO]   = ito;
        word[CTRL_CONT]  = cont;
        word[CTRL_START] = start;
        word[CTRL_STOP]  = stop;
        return word;
    endfunction

endpackage

// File: rtl/easy_timer_master.sv
// Avalon-MM master that programs, starts, stops and services the interval
// timer on behalf of local logic, counting ticks and reading snapshots.
module easy_timer_master
    import easy_timer_pkg::*;
#(
    parameter bit CONTINUOUS = 1'b1,
    parameter int TICK_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_stop,
    input  logic              snap_req,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snapshot,
    output logic              snap_valid,
    output logic              cmd_err
);

    state_t      state;
    logic [31:0] period;
    logic        period_ok;

    assign period_ok = (cmd_period != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            period     <= '0;
            tick_count <= '0;
            snapshot   <= '0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        if (period_ok) begin
                            period     <= cmd_period;
                            tick_count <= '0;
                            state      <= WR_PL;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                WR_PL:   state <= WR_PH;
                WR_PH:   state <= WR_CTRL;
                WR_CTRL: state <= RUN;
                RUN: begin
                    if (cmd_start) begin
                        if (period_ok) begin
                            period     <= cmd_period;
                            tick_count <= '0;
                            state      <= WR_PL;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end else if (cmd_stop) begin
                        state <= STOP_WR;
                    end else if (timer_irq) begin
                        state <= CLR_ST;
                    end else if (snap_req) begin
                        state <= SNAP_WR;
                    end
                end
                STOP_WR: state <= IDLE;
                CLR_ST: begin
                    tick_count <= tick_count + TICK_W'(1);
                    state      <= CONTINUOUS ? RUN : STOP_WR;
                end
                SNAP_WR: state <= RD_L;
                RD_L:    state <= RD_H;
                // Slave registers its read data, so each half arrives one cycle after its address.
                RD_H: begin
                    snapshot[15:0] <= avm_readdata;
                    state          <= RD_DONE;
                end
                RD_DONE: begin
                    snapshot[31:16] <= avm_readdata;
                    state           <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus signals are a pure decode of the state so an async reset idles the bus at once.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = ADDR_STATUS;
        avm_writedata  = '0;
        case (state)
            WR_PL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_PERIODL;
                avm_writedata  = period[15:0];
            end
            WR_PH: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_PERIODH;
                avm_writedata  = period[31:16];
            end
            WR_CTRL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_CONTROL;
                avm_writedata  = control_word(1'b1, CONTINUOUS, 1'b1, 1'b0);
            end
            STOP_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_CONTROL;
                avm_writedata  = control_word(1'b0, 1'b0, 1'b0, 1'b1);
            end
            CLR_ST: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_STATUS;
            end
            SNAP_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = ADDR_SNAPL;
            end
            RD_L: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_SNAPL;
            end
            RD_H, RD_DONE: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_SNAPH;
            end
            default: ;
        endcase
    end

    assign busy       = (state != IDLE) && (state != RUN);
    assign running    = (state == RUN);
    assign tick       = (state == CLR_ST);
    // Marks the cycle whose closing edge writes the upper snapshot half.
    assign snap_valid = (state == RD_DONE);

endmodule
